centroid_divider: RTL

Sequential divider stage that consumes the accumulated first moments (H_TOTAL, V_TOTAL) and pixel count (SUM) of a 64x64 binary frame and produces the fixed-point centroid coordinates CX = H_TOTAL/SUM and CY = V_TOTAL/SUM. It sits directly downstream of the centroid accumulator and starts on that stage's one-cycle VALID pulse. A single shared radix-2 restoring divider computes X, then Y. Results are held stable for the downstream tracking/output logic until the next frame.

---
 rtl/centroid_divider.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/centroid_divider.sv
// Centroid divider: CX = H_TOTAL/SUM and CY = V_TOTAL/SUM in unsigned Q6.FRAC_BITS.
// It uses one shared radix-2 restoring divider, first on X and then on Y.
// Latency: OUT_VALID comes 2N+1 cycles after VALID, where N = 18+FRAC_BITS. An empty frame gives OUT_VALID 1 cycle after VALID.
// Backpressure: none. A VALID that arrives while not IDLE is dropped, and OVERRUN pulses on the next cycle.
// Optional build macro CENTROID_ROUND_EN: round half-up at the LSB instead of truncating.
module centroid_divider #(
  parameter int FRAC_BITS = 2
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   VALID,
  input  logic [17:0]            H_TOTAL,
  input  logic [17:0]            V_TOTAL,
  input  logic [12:0]            SUM,
  output logic [6+FRAC_BITS-1:0] CX,
  output logic [6+FRAC_BITS-1:0] CY,
  output logic                   OUT_VALID,
  output logic                   EMPTY,
  output logic                   BUSY,
  output logic                   OVERRUN
);

  localparam int N  = 18 + FRAC_BITS;   // dividend / quotient width
  localparam int OW = 6 + FRAC_BITS;    // result width
  localparam int CW = $clog2(N);        // step counter width

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [12:0]     sum_r;      // latched divisor
  logic [N-1:0]    dvd;        // working dividend, fills with quotient bits as it shifts
  logic [N-1:0]    dvd_y;      // Y dividend parked while X is divided
  logic [13:0]     rem;        // partial remainder, always < SUM
  logic [CW-1:0]   cnt;        // remaining steps minus one
  logic [OW-1:0]   qx;         // X quotient held until Y finishes

  logic [N-1:0]    dvd_x_ld;
  logic [N-1:0]    dvd_y_ld;
  logic [14:0]     rem_sh;
  logic            ge;
  logic [13:0]     rem_nxt;
  logic [N-1:0]    dvd_nxt;
  logic            last;

  // The scaled dividends. In the rounding build, half the divisor is added so that truncation rounds half-up.
`ifdef CENTROID_ROUND_EN
  assign dvd_x_ld = (N'(H_TOTAL) << FRAC_BITS) + N'(SUM >> 1);
  assign dvd_y_ld = (N'(V_TOTAL) << FRAC_BITS) + N'(SUM >> 1);
`else
  assign dvd_x_ld = N'(H_TOTAL) << FRAC_BITS;
  assign dvd_y_ld = N'(V_TOTAL) << FRAC_BITS;
`endif

  // One restoring step: shift the next dividend MSB into the remainder, then subtract the divisor if it fits.
  always_comb begin
    rem_sh  = {rem, dvd[N-1]};
    ge      = (rem_sh >= {2'b00, sum_r});
    rem_nxt = ge ? 14'(rem_sh - {2'b00, sum_r}) : rem_sh[13:0];
    dvd_nxt = {dvd[N-2:0], ge};
    last    = (cnt == '0);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. An empty frame skips both divisions.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (VALID) state_nxt = (SUM == 13'd0) ? DONE : DIV_X;
      DIV_X:   if (last)  state_nxt = DIV_Y;
      DIV_Y:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. This block latches the operands, runs the divider steps and writes results on the way into DONE.
  // Writing on the way into DONE means CX/CY/EMPTY are already valid while OUT_VALID is high.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      sum_r   <= '0;
      dvd     <= '0;
      dvd_y   <= '0;
      rem     <= '0;
      cnt     <= '0;
      qx      <= '0;
      CX      <= '0;
      CY      <= '0;
      EMPTY   <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      OVERRUN <= VALID && (state != IDLE);
      case (state)
        IDLE: begin
          if (VALID) begin
            sum_r <= SUM;
            dvd   <= dvd_x_ld;
            dvd_y <= dvd_y_ld;
            rem   <= '0;
            cnt   <= CW'(N - 1);
            if (SUM == 13'd0) begin
              CX    <= '0;
              CY    <= '0;
              EMPTY <= 1'b1;
            end
          end
        end
        DIV_X: begin
          if (last) begin
            qx    <= dvd_nxt[OW-1:0];
            dvd   <= dvd_y;
            rem   <= '0;
            cnt   <= CW'(N - 1);
          end else begin
            dvd   <= dvd_nxt;
            rem   <= rem_nxt;
            cnt   <= cnt - CW'(1);
          end
        end
        DIV_Y: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
          if (last) begin
            CX    <= qx;
            CY    <= dvd_nxt[OW-1:0];
            EMPTY <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY      = (state != IDLE);
  assign OUT_VALID = (state == DONE);

endmodule
